// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared types, segment table and helpers for the 7-segment display path
package sevenseg_pkg;

   typedef logic [6:0] seg_t;

   typedef enum logic [1:0] {
      CTRL_IDLE,
      CTRL_CONVERT,
      CTRL_UPDATE
   } ctrl_state_t;

   localparam seg_t SEG_BLANK = 7'h7F;
   localparam seg_t SEG_DASH  = 7'b0111111;

   localparam seg_t SEG_DIGIT [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   // Non-decimal nibbles never occur from a valid conversion; show a dash rather than garbage.
   function automatic seg_t bcd_to_seg(input logic [3:0] nibble);
      if (nibble > 4'd9)
         return SEG_DASH;
      return SEG_DIGIT[nibble];
   endfunction

   function automatic logic [63:0] max_display(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++)
         r = r * 64'd10;
      return r - 64'd1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative shift-add-3 binary to BCD converter, one input bit per cycle
module bin2bcd_seq #(
   parameter int W = 7,
   parameter int N = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [W-1:0]   value,
   output logic           busy,
   output logic           done,
   output logic [4*N-1:0] bcd
);

   localparam int CW = $clog2(W + 1);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic {S_IDLE, S_CONV} state_t;

   state_t         state, state_n;
   logic [W-1:0]   bin_q;
   logic [4*N-1:0] bcd_q;
   logic [4*N-1:0] adj;
   logic [CW-1:0]  cnt;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < N; i++)
         if (bcd_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE: if (start) state_n = S_CONV;
         S_CONV: if (cnt == LAST) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_IDLE;
         bin_q <= '0;
         bcd_q <= '0;
         cnt   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         done  <= 1'b0;
         if (state == S_IDLE && start) begin
            bin_q <= value;
            bcd_q <= '0;
            cnt   <= '0;
         end else if (state == S_CONV) begin
            bcd_q <= {adj[4*N-2:0], bin_q[W-1]};
            bin_q <= bin_q << 1;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST)
               done <= 1'b1;
         end
      end
   end

   assign busy = (state == S_CONV);
   assign bcd  = bcd_q;

endmodule

// File: rtl/sevenseg_ctrl.sv
// rtl/sevenseg_ctrl.sv - load handshake, BCD conversion, segment encoding and scan prescaler
module sevenseg_ctrl
   import sevenseg_pkg::*;
#(
   parameter int N        = 2,
   parameter int W        = 7,
   parameter int SCAN_DIV = 50000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] value,
   input  logic         load,
   output logic         ready,
   output logic         overflow,
   output logic         scan_en,
   output seg_t         digit_values [N]
);

   localparam logic [63:0] MAXV = max_display(N);
   localparam int          PW   = $clog2(SCAN_DIV);

   ctrl_state_t    state, state_n;
   logic           start, busy, done;
   logic           ovf_pending;
   logic [4*N-1:0] bcd;
   logic [PW-1:0]  pcnt;
   logic           allz;
   seg_t           seg_next [N];

   assign ready = (state == CTRL_IDLE);
   assign start = ready && load && !busy;

   bin2bcd_seq #(.W(W), .N(N)) u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .value (value),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   always_comb begin
      state_n = state;
      case (state)
         CTRL_IDLE:    if (start) state_n = CTRL_CONVERT;
         CTRL_CONVERT: if (done) state_n = CTRL_UPDATE;
         CTRL_UPDATE:  state_n = CTRL_IDLE;
         default:      state_n = CTRL_IDLE;
      endcase
   end

   // Walk from the most significant digit down so allz means "this and every higher digit is zero".
   always_comb begin
      allz = 1'b1;
      for (int i = N - 1; i >= 0; i--) begin
         allz = allz && (bcd[4*i +: 4] == 4'd0);
         if (ovf_pending)
            seg_next[i] = SEG_DASH;
         else if (i != 0 && allz)
            seg_next[i] = SEG_BLANK;
         else
            seg_next[i] = bcd_to_seg(bcd[4*i +: 4]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= CTRL_IDLE;
         ovf_pending <= 1'b0;
         overflow    <= 1'b0;
         for (int i = 0; i < N; i++)
            digit_values[i] <= SEG_BLANK;
      end else begin
         state <= state_n;
         if (start)
            ovf_pending <= (64'(value) > MAXV);
         if (state == CTRL_UPDATE) begin
            overflow <= ovf_pending;
            for (int i = 0; i < N; i++)
               digit_values[i] <= seg_next[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pcnt    <= '0;
         scan_en <= 1'b0;
      end else begin
         scan_en <= (pcnt == PW'(SCAN_DIV - 1));
         pcnt    <= (pcnt == PW'(SCAN_DIV - 1)) ? '0 : pcnt + PW'(1);
      end
   end

endmodule

// File: tb/tb_sevenseg_ctrl.sv
// tb/tb_sevenseg_ctrl.sv - scoreboard bench for sevenseg_ctrl with directed vectors
module tb_sevenseg_ctrl;

   typedef struct {
      logic [6:0] d1;
      logic [6:0] d0;
      logic       ovf;
      int         c;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [6:0] value = '0;
   logic       load = 1'b0;
   logic       ready, overflow, scan_en;
   logic [6:0] dv [2];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic reset_d = 1'b0;
   logic prev_ready = 1'b1;
   exp_t q[$];

   sevenseg_ctrl #(.N(2), .W(7), .SCAN_DIV(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .value        (value),
      .load         (load),
      .ready        (ready),
      .overflow     (overflow),
      .scan_en      (scan_en),
      .digit_values (dv)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      reset_d <= reset;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset_d && ready && !prev_ready) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update actual=%0h_%0h required=none", dv[1], dv[0]);
         end else begin
            e = q.pop_front();
            chk("latency", cyc, e.c + 9);
            chk("digit1", {25'd0, dv[1]}, {25'd0, e.d1});
            chk("digit0", {25'd0, dv[0]}, {25'd0, e.d0});
            chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
         end
      end
      prev_ready <= ready;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 100; i++) begin
         if (ready) return;
         tick();
      end
      chk("ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   task automatic issue(input logic [6:0] v);
      value = v;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic do_load(input logic [6:0] v, input logic [6:0] d1, input logic [6:0] d0,
                          input logic ovf);
      exp_t e;
      wait_ready();
      issue(v);
      e.d1 = d1;
      e.d0 = d0;
      e.ovf = ovf;
      e.c = cyc;
      q.push_back(e);
      wait_ready();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      repeat (3) tick();
      chk("rst_digit1", {25'd0, dv[1]}, 32'h7F);
      chk("rst_digit0", {25'd0, dv[0]}, 32'h7F);
      chk("rst_ready", {31'd0, ready}, 32'd1);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_scan_en", {31'd0, scan_en}, 32'd0);
      reset = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk($sformatf("scan_en_edge%0d", k), {31'd0, scan_en}, (k % 4 == 0) ? 32'd1 : 32'd0);
      end

      do_load(7'd42,  7'b0011001, 7'b0100100, 1'b0);
      do_load(7'd7,   7'h7F,      7'b1111000, 1'b0);
      do_load(7'd0,   7'h7F,      7'b1000000, 1'b0);
      do_load(7'd10,  7'b1111001, 7'b1000000, 1'b0);
      do_load(7'd100, 7'b0111111, 7'b0111111, 1'b1);
      do_load(7'd99,  7'b0010000, 7'b0010000, 1'b0);
      do_load(7'd127, 7'b0111111, 7'b0111111, 1'b1);

      // Second load lands mid-conversion and must be dropped.
      begin
         exp_t e;
         wait_ready();
         issue(7'd42);
         e.d1 = 7'b0011001;
         e.d0 = 7'b0100100;
         e.ovf = 1'b0;
         e.c = cyc;
         q.push_back(e);
         repeat (2) tick();
         issue(7'd55);
         wait_ready();
         repeat (3) tick();
      end
      do_load(7'd55, 7'b0010010, 7'b0010010, 1'b0);

      // Reset on the 4th CONVERT edge aborts the conversion.
      wait_ready();
      issue(7'd42);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("abort_digit1", {25'd0, dv[1]}, 32'h7F);
      chk("abort_digit0", {25'd0, dv[0]}, 32'h7F);
      chk("abort_ready", {31'd0, ready}, 32'd1);
      chk("abort_overflow", {31'd0, overflow}, 32'd0);
      repeat (20) tick();
      chk("abort_hold_digit1", {25'd0, dv[1]}, 32'h7F);
      chk("abort_hold_digit0", {25'd0, dv[0]}, 32'h7F);

      for (int i = 0; i < 50 && q.size() != 0; i++)
         tick();
      chk("scoreboard_empty", q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
